// File: rtl/imem_loader.sv
// imem_loader: fills the writable instruction memory from a byte stream.
// Bytes are packed little-endian into N-bit words, written to consecutive
// word addresses starting at 0, and the core is held for the whole load.
//
// Byte handshake: a byte moves from the host to the loader on a rising
// edge where byte_valid and byte_ready are both high.  The host may raise
// byte_valid at any time and must hold byte_in stable until that edge.
// byte_ready is high only in RECV.  An abort in the same cycle cancels the
// transfer; the byte is dropped and the load ends in ERR.
module imem_loader #(
    parameter int N      = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [N-1:0]      wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        dbg_state
);

    localparam int BYTES  = N / 8;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RECV  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] ERR   = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W:0]   len_q;
    logic [BIDX_W-1:0] byte_idx;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W:0]   next_cnt;

    // Count of words written once the current WRITE completes.
    assign next_cnt = word_cnt + 1'b1;

    // Load sequencer: state, latched length, byte/word counters and the write port registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            len_q    <= '0;
            byte_idx <= '0;
            word_cnt <= '0;
            waddr    <= '0;
            wdata    <= '0;
            error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= len;
                        if (len == '0 || len > DEPTH_L) begin
                            // Invalid length: never enter RECV, flag it.
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            state    <= RECV;
                            error    <= 1'b0;
                            waddr    <= '0;
                            byte_idx <= '0;
                            word_cnt <= '0;
                        end
                    end
                end

                RECV: begin
                    if (abort) begin
                        // Abort wins over a byte presented in the same cycle.
                        state <= ERR;
                        error <= 1'b1;
                    end else if (byte_valid) begin
                        // Byte k lands in bits [8k+7:8k]; the other lanes keep their value.
                        for (int k = 0; k < BYTES; k++) begin
                            if (byte_idx == BIDX_W'(k)) begin
                                wdata[8*k +: 8] <= byte_in;
                            end
                        end
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == LAST_BYTE) begin
                            state <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    if (abort) begin
                        // The write is suppressed combinationally; no counters move.
                        state <= ERR;
                        error <= 1'b1;
                    end else begin
                        word_cnt <= next_cnt;
                        byte_idx <= '0;
                        if (next_cnt == len_q) begin
                            // Last word: keep waddr so it never steps past len-1.
                            state <= DONE;
                        end else begin
                            waddr <= waddr + 1'b1;
                            state <= RECV;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                ERR: begin
                    state <= IDLE;
                    error <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode: everything but the write port registers is a function of state (and abort for we).
    always_comb begin
        byte_ready = 1'b0;
        we         = 1'b0;
        busy       = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        dbg_state  = state;
        case (state)
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                cpu_hold   = 1'b1;
            end
            WRITE: begin
                we       = ~abort;
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b1;
            end
            ERR: begin
                cpu_hold = 1'b1;
            end
            default: begin
                byte_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: basic load, stream bubbles, bad
// lengths, abort, full-depth load with an ignored start, reset mid-load.
module tb_imem_loader;

    localparam int N      = 32;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RECV = 3'd1;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              abort;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [N-1:0]      wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [2:0]        dbg_state;

    imem_loader #(.N(N), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .abort      (abort),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .dbg_state  (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed write/transfer/done events, sampled mid-cycle
    logic [ADDR_W+N-1:0] got_q[$];
    logic [ADDR_W+N-1:0] exp_q[$];
    int                  we_cyc_q[$];
    int                  xfer_q[$];
    int                  done_q[$];
    logic [1:0]          done_flags_q[$];

    always @(negedge clk) begin
        if (we) begin
            got_q.push_back({waddr, wdata});
            we_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_q.push_back(cyc);
            done_flags_q.push_back({cpu_hold, busy});
        end
        if (byte_valid && byte_ready && !abort) xfer_q.push_back(cyc);
    end

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Driver tasks
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        byte_valid = 1'b0; byte_in = 8'h00; len = '0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        byte_valid = 1'b1;
        byte_in    = b;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            if (byte_ready && !abort) ok = 1'b1;
            cycle();
        end
        total_cnt++;
        if (!ok) $display("FAIL byte_accept: byte %02h byte_ready=%0b, want 1 within 40 cycles", b, byte_ready);
        else pass_cnt++;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic issue_start(input logic [ADDR_W:0] l);
        start = 1'b1;
        len   = l;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit found;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (dbg_state == S_IDLE) found = 1'b1;
            cycle();
        end
        total_cnt++;
        if (!found) $display("FAIL wait_idle: state=%0d, want %0d within 20 cycles", dbg_state, S_IDLE);
        else pass_cnt++;
    endtask

    // Scenarios
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total_cnt++;
        if ({byte_ready, we, cpu_hold, busy, done, error} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000", {byte_ready, we, cpu_hold, busy, done, error});
        else pass_cnt++;
        total_cnt++;
        if (waddr !== '0) $display("FAIL reset_waddr: got %0d want 0", waddr); else pass_cnt++;
        total_cnt++;
        if (wdata !== '0) $display("FAIL reset_wdata: got %h want 0", wdata); else pass_cnt++;
        total_cnt++;
        if (dbg_state !== S_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); else pass_cnt++;
        cycle();
    endtask

    task automatic test_basic();
        int wb, xb, db;
        wb = got_q.size(); xb = xfer_q.size(); db = done_q.size();
        start = 1'b1; len = 7'd2;
        @(negedge clk);
        total_cnt++;
        if (cpu_hold !== 1'b0) $display("FAIL basic_hold_pre: got %0b want 0", cpu_hold); else pass_cnt++;
        cycle();
        start = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({cpu_hold, busy, dbg_state} !== {2'b11, S_RECV})
            $display("FAIL basic_recv: got hold/busy/state %b want 11001", {cpu_hold, busy, dbg_state});
        else pass_cnt++;
        cycle();
        send_word(32'hF8000000);
        send_word(32'hF8008001);
        byte_valid = 1'b0;
        wait_idle();
        total_cnt++;
        if (got_q.size() - wb !== 2) $display("FAIL basic_we_count: got %0d want 2", got_q.size() - wb); else pass_cnt++;
        total_cnt++;
        if (got_q[wb] !== {6'd0, 32'hF8000000}) $display("FAIL basic_word0: got %h want %h", got_q[wb], {6'd0, 32'hF8000000}); else pass_cnt++;
        total_cnt++;
        if (got_q[wb+1] !== {6'd1, 32'hF8008001}) $display("FAIL basic_word1: got %h want %h", got_q[wb+1], {6'd1, 32'hF8008001}); else pass_cnt++;
        total_cnt++;
        if (we_cyc_q[wb] - xfer_q[xb] !== 4) $display("FAIL basic_latency: got %0d want 4", we_cyc_q[wb] - xfer_q[xb]); else pass_cnt++;
        total_cnt++;
        if (done_q.size() - db !== 1) $display("FAIL basic_done_count: got %0d want 1", done_q.size() - db); else pass_cnt++;
        total_cnt++;
        if (done_q[db] !== we_cyc_q[wb+1] + 1) $display("FAIL basic_done_cycle: got %0d want %0d", done_q[db], we_cyc_q[wb+1] + 1); else pass_cnt++;
        total_cnt++;
        if (done_flags_q[db] !== 2'b10) $display("FAIL basic_done_flags: hold/busy got %b want 10", done_flags_q[db]); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (cpu_hold !== 1'b0) $display("FAIL basic_hold_post: got %0b want 0", cpu_hold); else pass_cnt++;
        cycle();
    endtask

    task automatic test_bubbles();
        logic [7:0] bytes [4];
        int wb;
        bytes[0] = 8'h4E; bytes[1] = 8'h00; bytes[2] = 8'h00; bytes[3] = 8'hB4;
        wb = got_q.size();
        issue_start(7'd1);
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i]);
            byte_valid = 1'b0;
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    @(negedge clk);
                    total_cnt++;
                    if ({byte_ready, dbg_state} !== {1'b1, S_RECV})
                        $display("FAIL bubble_ready: got ready/state %b want 1001", {byte_ready, dbg_state});
                    else pass_cnt++;
                    cycle();
                end
            end
        end
        wait_idle();
        total_cnt++;
        if (got_q.size() - wb !== 1) $display("FAIL bubble_we_count: got %0d want 1", got_q.size() - wb); else pass_cnt++;
        total_cnt++;
        if (got_q[wb] !== {6'd0, 32'hB400004E}) $display("FAIL bubble_word: got %h want %h", got_q[wb], {6'd0, 32'hB400004E}); else pass_cnt++;
    endtask

    task automatic test_bad_len();
        logic [ADDR_W:0] bad [2];
        int wb;
        bad[0] = 7'd0; bad[1] = 7'd65;
        wb = got_q.size();
        for (int i = 0; i < 2; i++) begin
            issue_start(bad[i]);
            @(negedge clk);
            total_cnt++;
            if ({dbg_state, error, cpu_hold, busy} !== {S_ERR, 3'b110})
                $display("FAIL badlen_err: len=%0d got state/err/hold/busy %b want 100110", bad[i], {dbg_state, error, cpu_hold, busy});
            else pass_cnt++;
            cycle();
            @(negedge clk);
            total_cnt++;
            if ({dbg_state, error} !== {S_IDLE, 1'b1})
                $display("FAIL badlen_sticky: len=%0d got state/err %b want 0001", bad[i], {dbg_state, error});
            else pass_cnt++;
            cycle();
        end
        total_cnt++;
        if (got_q.size() !== wb) $display("FAIL badlen_no_we: got %0d writes want 0", got_q.size() - wb); else pass_cnt++;
        issue_start(7'd1);
        @(negedge clk);
        total_cnt++;
        if ({dbg_state, error} !== {S_RECV, 1'b0})
            $display("FAIL badlen_clear: got state/err %b want 0010", {dbg_state, error});
        else pass_cnt++;
        cycle();
        send_word(32'h44332211);
        byte_valid = 1'b0;
        wait_idle();
        total_cnt++;
        if (got_q[wb] !== {6'd0, 32'h44332211}) $display("FAIL badlen_word: got %h want %h", got_q[wb], {6'd0, 32'h44332211}); else pass_cnt++;
    endtask

    task automatic test_abort();
        int wb;
        wb = got_q.size();
        issue_start(7'd3);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        byte_in = 8'h07; byte_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (we !== 1'b0) $display("FAIL abort_we: got %0b want 0", we); else pass_cnt++;
        cycle();
        abort = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({dbg_state, error} !== {S_ERR, 1'b1}) $display("FAIL abort_err: got state/err %b want 1001", {dbg_state, error}); else pass_cnt++;
        cycle();
        @(negedge clk);
        total_cnt++;
        if ({dbg_state, error} !== {S_IDLE, 1'b1}) $display("FAIL abort_idle: got state/err %b want 0001", {dbg_state, error}); else pass_cnt++;
        cycle();
        for (int i = 0; i < 10; i++) cycle();
        total_cnt++;
        if (got_q.size() - wb !== 1) $display("FAIL abort_we_count: got %0d want 1", got_q.size() - wb); else pass_cnt++;
        total_cnt++;
        if (got_q[wb] !== {6'd0, 32'h04030201}) $display("FAIL abort_word0: got %h want %h", got_q[wb], {6'd0, 32'h04030201}); else pass_cnt++;
    endtask

    task automatic test_full_depth();
        int wb, xb, db, bad;
        logic [7:0]  b;
        logic [31:0] w32;
        wb = got_q.size(); xb = xfer_q.size(); db = done_q.size();
        exp_q.delete();
        issue_start(7'd64);
        for (int w = 0; w < DEPTH; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'(w * 4 + k) ^ 8'hC3;
                w32[8*k +: 8] = b;
                if (w == 10 && k == 1) begin
                    start = 1'b1;
                    len   = 7'd5;
                end
                send_byte(b);
                start = 1'b0;
            end
            exp_q.push_back({6'(w), w32});
        end
        byte_valid = 1'b0;
        wait_idle();
        total_cnt++;
        if (got_q.size() - wb !== DEPTH) $display("FAIL full_we_count: got %0d want %0d", got_q.size() - wb, DEPTH); else pass_cnt++;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (got_q[wb+i] !== exp_q[i]) begin
                if (bad < 4) $display("FAIL full_word: index %0d got %h want %h", i, got_q[wb+i], exp_q[i]);
                bad++;
            end
        end
        total_cnt++;
        if (bad != 0) $display("FAIL full_words: %0d words differ, want 0", bad); else pass_cnt++;
        total_cnt++;
        if (we_cyc_q[wb+DEPTH-1] - xfer_q[xb] !== 319)
            $display("FAIL full_span: got %0d want 319", we_cyc_q[wb+DEPTH-1] - xfer_q[xb]);
        else pass_cnt++;
        total_cnt++;
        if (done_q.size() - db !== 1) $display("FAIL full_done_count: got %0d want 1", done_q.size() - db); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int wb;
        wb = got_q.size();
        issue_start(7'd8);
        for (int i = 0; i < 22; i++) send_byte(8'(8'h90 + i));
        reset = 1'b1; byte_valid = 1'b0;
        cycle();
        @(negedge clk);
        total_cnt++;
        if ({byte_ready, we, cpu_hold, busy, done, error} !== 6'b0)
            $display("FAIL rstmid_flags: got %b want 000000", {byte_ready, we, cpu_hold, busy, done, error});
        else pass_cnt++;
        total_cnt++;
        if ({waddr, wdata} !== '0) $display("FAIL rstmid_port: got %h want 0", {waddr, wdata}); else pass_cnt++;
        total_cnt++;
        if (dbg_state !== S_IDLE) $display("FAIL rstmid_state: got %0d want %0d", dbg_state, S_IDLE); else pass_cnt++;
        cycle();
        reset = 1'b0;
        total_cnt++;
        if (got_q.size() - wb !== 5) $display("FAIL rstmid_prior_writes: got %0d want 5", got_q.size() - wb); else pass_cnt++;
        wb = got_q.size();
        issue_start(7'd1);
        send_word(32'hCAFEF00D);
        byte_valid = 1'b0;
        wait_idle();
        total_cnt++;
        if (got_q[wb] !== {6'd0, 32'hCAFEF00D}) $display("FAIL rstmid_reload: got %h want %h", got_q[wb], {6'd0, 32'hCAFEF00D}); else pass_cnt++;
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_basic();
        test_bubbles();
        test_bad_len();
        test_abort();
        test_full_depth();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

endmodule
